// File: rtl/shift_load_arb.sv
// Round-robin arbiter that feeds a 4-stage, 4-bit shift chain one 16-bit word at a time.
// Each word goes in most-significant nibble first, then the chain is frozen for HOLD cycles.
module shift_load_arb #(
    parameter int HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [15:0] b_data,
    output logic        b_ready,
    output logic        sh_enable,
    output logic [3:0]  sh_din,
    output logic        busy,
    output logic        done,
    output logic        done_id
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] word_q, word_d;
    logic        grant_q, grant_d;   // last requester granted: 0 = A, 1 = B
    logic        id_q, id_d;
    logic        a_win, b_win;

    // A requester wins if it is alone or if the other one was served last.
    assign a_win   = a_valid & (~b_valid | grant_q);
    assign b_win   = b_valid & (~a_valid | ~grant_q);
    assign a_ready = ~reset & (state_q == ST_IDLE) & a_win;
    assign b_ready = ~reset & (state_q == ST_IDLE) & b_win;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        grant_d = grant_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (a_ready) begin
                    word_d  = a_data;
                    grant_d = 1'b0;
                    id_d    = 1'b0;
                    k_d     = 2'd0;
                    state_d = ST_LOAD;
                end else if (b_ready) begin
                    word_d  = b_data;
                    grant_d = 1'b1;
                    id_d    = 1'b1;
                    k_d     = 2'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    cnt_d   = 4'd0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            cnt_q   <= 4'd0;
            word_q  <= 16'h0000;
            grant_q <= 1'b1;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            grant_q <= grant_d;
            id_q    <= id_d;
        end
    end

    // Chain-side outputs decode registered state only.
    always_comb begin
        sh_din = 4'h0;
        if (state_q == ST_LOAD) begin
            case (k_q)
                2'd0:    sh_din = word_q[15:12];
                2'd1:    sh_din = word_q[11:8];
                2'd2:    sh_din = word_q[7:4];
                default: sh_din = word_q[3:0];
            endcase
        end
    end

    assign sh_enable = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_HOLD) && (cnt_q == 4'd0);
    assign done_id   = id_q;

endmodule

// File: tb/tb_shift_load_arb.sv
// Directed bench for shift_load_arb: a scoreboard of expected words/requesters is checked
// against the serialised nibbles, a bench-side shift chain, and the done flag.
module tb_shift_load_arb;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [15:0] a_data = 16'h0, b_data = 16'h0;
    logic        a_ready, b_ready, sh_enable, busy, done, done_id;
    logic [3:0]  sh_din;

    logic        a1_valid = 1'b0, b1_valid = 1'b0;
    logic [15:0] a1_data = 16'h0, b1_data = 16'h0;
    logic        a1_ready, b1_ready, sh_enable1, busy1, done1, done_id1;
    logic [3:0]  sh_din1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] word;
        logic        id;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] chain = 16'h0;   // [15:12] = stage 3 ... [3:0] = stage 0
    logic [15:0] asm_word = 16'h0;
    int          nib_cnt = 0;

    shift_load_arb #(.HOLD(2)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sh_enable(sh_enable), .sh_din(sh_din), .busy(busy),
        .done(done), .done_id(done_id)
    );

    shift_load_arb #(.HOLD(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_valid(a1_valid), .a_data(a1_data), .a_ready(a1_ready),
        .b_valid(b1_valid), .b_data(b1_data), .b_ready(b1_ready),
        .sh_enable(sh_enable1), .sh_din(sh_din1), .busy(busy1),
        .done(done1), .done_id(done_id1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset)          chain <= 16'h0;
        else if (sh_enable) chain <= {chain[11:0], sh_din};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic push_exp(input logic [15:0] w, input logic id);
        exp_t e;
        e.word = w;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    // Scoreboard: collect nibbles while enabled, compare everything on done.
    always @(negedge clk) begin
        if (reset) begin
            nib_cnt  = 0;
            asm_word = 16'h0;
        end else begin
            check("one_ready", {31'd0, a_ready & b_ready}, 32'd0);
            if (sh_enable) begin
                asm_word = {asm_word[11:0], sh_din};
                nib_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_nibbles", {16'd0, asm_word}, {16'd0, e.word});
                    check("sb_enable_len", nib_cnt, 32'd4);
                    check("sb_done_id", {31'd0, done_id}, {31'd0, e.id});
                    check("sb_chain", {16'd0, chain}, {16'd0, e.word});
                end
                nib_cnt  = 0;
                asm_word = 16'h0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int at, output logic who);
        bit ok;
        ok  = 1'b0;
        at  = 0;
        who = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (a_valid && a_ready) begin
                who = 1'b0; ok = 1'b1; at = cyc;
            end else if (b_valid && b_ready) begin
                who = 1'b1; ok = 1'b1; at = cyc;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int          at, prev;
        logic        who;
        logic [15:0] w;
        int          acc1, done1_cnt, prev1;

        // Reset with both requesters valid.
        a_valid = 1'b1; b_valid = 1'b1;
        a_data  = 16'hA5C3; b_data = 16'h2222;
        step();
        #1;
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        check("rst_outputs", {24'd0, sh_enable, sh_din, busy, done, done_id}, 32'd0);
        step();

        // Release: A wins the first tie; single load of A5C3.
        reset = 1'b0;
        #1;
        check("first_grant_a", {30'd0, a_ready, b_ready}, 32'd2);
        push_exp(16'hA5C3, 1'b0);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        w = 16'hA5C3;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("load_enable", {31'd0, sh_enable}, 32'd1);
            check("load_nibble", {28'd0, sh_din}, {28'd0, w[15-4*i -: 4]});
            step();
        end
        #1;
        check("done_cycle5", {30'd0, done, sh_enable}, 32'd2);
        check("done_id_a", {31'd0, done_id}, 32'd0);
        step();
        a_valid = 1'b1;
        #1;
        check("no_ready_hold", {30'd0, a_ready, busy}, 32'd1);
        step();
        #1;
        check("ready_cycle7", {30'd0, a_ready, busy}, 32'd2);
        a_valid = 1'b0;
        step();

        // Contention from a fresh reset: A, B, A, B, 7 cycles apart.
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_data = 16'h1111; b_data = 16'h2222;
        a_valid = 1'b1; b_valid = 1'b1;
        prev = 0;
        for (int t = 0; t < 4; t++) begin
            wait_accept(at, who);
            check("cont_winner", {31'd0, who}, (t % 2 == 0) ? 32'd0 : 32'd1);
            push_exp((t % 2 == 0) ? 16'h1111 : 16'h2222, (t % 2 == 0) ? 1'b0 : 1'b1);
            if (t > 0) check("cont_gap", at - prev, 32'd7);
            prev = at;
        end

        // Lone B after B was last served; b_data change after accept is ignored.
        a_valid = 1'b0;
        b_data  = 16'h0F0F;
        for (int t = 0; t < 3; t++) begin
            wait_accept(at, who);
            check("lone_winner_b", {31'd0, who}, 32'd1);
            push_exp(16'h0F0F, 1'b1);
            check("lone_gap", at - prev, 32'd7);
            prev = at;
        end
        b_valid = 1'b0;
        repeat (8) step();

        // Abort: reset during the second LOAD cycle.
        a_data = 16'hBEEF; a_valid = 1'b1;
        wait_accept(at, who);
        check("abort_winner", {31'd0, who}, 32'd0);
        a_valid = 1'b0;
        step();
        reset = 1'b1; a_valid = 1'b1;
        #1;
        check("rst_ready_low", {31'd0, a_ready}, 32'd0);
        step();
        check("abort_outputs", {24'd0, sh_enable, sh_din, busy, done, a_ready}, 32'd0);
        reset = 1'b0; a_data = 16'h1234;
        #1;
        check("post_abort_ready", {31'd0, a_ready}, 32'd1);
        push_exp(16'h1234, 1'b0);
        step();
        a_valid = 1'b0;
        repeat (8) step();

        // Withdrawn A request during a B load.
        b_data = 16'h0F0F; b_valid = 1'b1;
        wait_accept(at, who);
        check("wd_winner_b", {31'd0, who}, 32'd1);
        push_exp(16'h0F0F, 1'b1);
        b_valid = 1'b0;
        step();
        a_valid = 1'b1;
        #1;
        check("wd_no_ready", {31'd0, a_ready}, 32'd0);
        step();
        a_valid = 1'b0;
        repeat (8) step();
        check("sb_drained", exp_q.size(), 32'd0);

        // HOLD = 1 instance: back-to-back B loads 6 cycles apart.
        b1_data = 16'h3C3C; b1_valid = 1'b1;
        acc1 = 0; done1_cnt = 0; prev1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done1) done1_cnt++;
            if (b1_valid && b1_ready) begin
                if (acc1 > 0) check("hold1_gap", cyc - prev1, 32'd6);
                prev1 = cyc;
                acc1++;
            end
            @(posedge clk);
            #1;
        end
        b1_valid = 1'b0;
        check("hold1_accepts", acc1, 32'd4);
        check("hold1_dones", done1_cnt, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_load_arb.md
# shift_load_arb

Arbiter and sequencer for the 4-stage, 4-bit daisy-chained shift register. It takes 16-bit words from two requesters (A, B) over valid/ready handshakes and picks one per transaction by round-robin. It serialises the chosen word into the chain as four nibbles, most-significant nibble first. It then holds the chain still for a fixed window, flagging which requester's word now sits in the four stage outputs. It drives the chain's enable and Din directly and shares its clock and reset.

## Interface
- HOLD, default 2: idle cycles after loading during which the chain is frozen (legal range 1..15).
- clk  in  1  rising-edge clock, shared with the shift chain.
- reset  in  1  synchronous, active-high; also drives the shift chain's reset.
- a_valid  in  1  requester A offers a_data.
- a_data  in  16  requester A word; nibble [15:12] ends in stage 3, [3:0] in stage 0.
- a_ready  out  1  A's word is accepted this cycle (a_valid & a_ready).
- b_valid, b_data, b_ready: same as A, for requester B.
- sh_enable  out  1  shift enable to the chain.
- sh_din  out  4  nibble presented to chain stage 0.
- busy  out  1  controller is not in IDLE.
- done  out  1  one-cycle pulse: chain outputs hold the complete word.
- done_id  out  1  requester of the word flagged by done (0 = A, 1 = B); stable from done until the next accept.

## Operation
- States: IDLE, LOAD (4 cycles, 2-bit nibble counter k = 0..3), HOLD (HOLD cycles, 4-bit counter).
- IDLE:
  - a_ready = a_valid & (~b_valid | last_grant == B).
  - b_ready = b_valid & (~a_valid | last_grant == A).
  - Exactly one ready is asserted when any valid is high; none otherwise.
  - On accept: capture the word, set last_grant and done_id to the winner, k = 0, go to LOAD.
  - Ready depends combinationally on valid. A requester may drop valid before it is accepted; nothing is captured.
- LOAD:
  - sh_enable = 1 and sh_din = word[15-4k -: 4], in order [15:12], [11:8], [7:4], [3:0].
  - Both readys are 0.
  - After k = 3, go to HOLD.
- HOLD:
  - sh_enable = 0 and sh_din = 0.
  - done = 1 in the first HOLD cycle only.
  - After HOLD cycles, return to IDLE.
- Decoding:
  - sh_enable, sh_din, busy, done and done_id come from registered state only (no input-to-output paths).
  - Only the readys are combinational from the valids.
- Outputs outside LOAD: sh_enable = 0 and sh_din = 4'h0.
- Reset:
  - state IDLE, last_grant = B (A wins the first tie), done_id = 0, captured word = 0.
  - All outputs are 0 in the cycle after reset is sampled high.
  - Readys stay 0 while reset is high.
- Reset mid-operation (LOAD or HOLD):
  - Abort; no done is issued for that word.
  - The chain is cleared by the same reset.
  - The aborted requester is not re-granted automatically; it must re-offer.
- Input changes: changes to a_data/b_data after acceptance have no effect.

## Timing
- Accept at the edge closing cycle 0.
- LOAD occupies cycles 1-4, with sh_enable high for exactly 4 consecutive cycles.
- Chain stages hold the full word from the edge closing cycle 4.
- done is high in cycle 5.
- HOLD occupies cycles 5..4+HOLD.
- First possible next accept is cycle 5+HOLD.
- Throughput: one word per 5+HOLD cycles when a requester is always valid.
- busy is high in cycles 1..4+HOLD.
- With both requesters continuously valid, grants alternate A, B, A, B, ...

## Test plan
- Reset: hold reset high 2 cycles with both valids high -> readys, sh_enable, sh_din, busy, done all 0. First grant after release goes to A.
- Single load: a_data = 16'hA5C3, a_valid for 1 cycle, HOLD = 2 -> sh_din = A, 5, C, 3 in cycles 1-4. done and done_id = 0 in cycle 5; at that point chain Dout3 = A, Dout2 = 5, Dout1 = C, Dout0 = 3. Next a_ready possible in cycle 7.
- Contention: a_data = 16'h1111 and b_data = 16'h2222 both continuously valid -> grants A, B, A, B with done_id 0, 1, 0, 1. Accepts are 7 cycles apart.
- Lone requester: only b_valid, data 16'h0F0F, for 3 consecutive transactions -> B granted every time despite last_grant = B. done_id = 1 each time.
- Abort: reset asserted in LOAD cycle 2 (k = 1) -> sh_enable 0 next cycle, busy 0, no done. Chain reads 0. A fresh a_valid is accepted the first cycle after reset drops.
- Withdrawn request: a_valid pulsed high then low while in LOAD -> never accepted, no extra done. HOLD = 1 back-to-back B loads accept 6 cycles apart.
